// File: rtl/led_status_tx_if.sv
// Host-facing byte/serial bundle for the LED status reporter: receiver byte
// strobe in, UART serial line and frame status out.
interface led_status_tx_if;
  logic [7:0] rx_byte;
  logic       rx_done;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  // rx_done is a one-cycle strobe qualifying rx_byte (no back-pressure);
  // tx_busy spans a frame and tx_done pulses once in the first idle cycle after it.
  modport master (
    output rx_byte, rx_done,
    input  tx, tx_busy, tx_done
  );

  modport slave (
    input  rx_byte, rx_done,
    output tx, tx_busy, tx_done
  );
endinterface

// File: rtl/led_status_tx.sv
// UART 8N1 transmitter reporting RGB LED level changes as 'R'/'r', 'G'/'g', 'B'/'b';
// a received '?' forces a full three-byte status report.
module led_status_tx #(
  parameter int CLKS_PER_BIT = 1250
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 led_r,
  input  logic                 led_g,
  input  logic                 led_b,
  led_status_tx_if.slave       bus,
  output logic [1:0]           dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_n;
  logic [7:0]      shreg, shreg_n;
  logic            tx_q, tx_n;
  logic            busy_q, busy_n;
  logic            done_q, done_n;
  logic            sh_r, sh_g, sh_b;
  logic            f_r, f_g, f_b;
  logic            req_r, req_g, req_b;
  logic            clr_r, clr_g, clr_b;
  logic            query;
  logic            wrap;

  // A channel asks to be reported while its level differs from what was last sent or a query forced it.
  assign req_r = (led_r != sh_r) | f_r;
  assign req_g = (led_g != sh_g) | f_g;
  assign req_b = (led_b != sh_b) | f_b;
  assign query = bus.rx_done && (bus.rx_byte == 8'h3F);
  assign wrap  = (cnt == CNT_MAX);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shreg_n = shreg;
    tx_n    = tx_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    clr_r   = 1'b0;
    clr_g   = 1'b0;
    clr_b   = 1'b0;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (req_r || req_g || req_b) begin
          if (req_r) begin
            shreg_n = led_r ? 8'h52 : 8'h72;
            clr_r   = 1'b1;
          end else if (req_g) begin
            shreg_n = led_g ? 8'h47 : 8'h67;
            clr_g   = 1'b1;
          end else begin
            shreg_n = led_b ? 8'h42 : 8'h62;
            clr_b   = 1'b1;
          end
          cnt_n   = '0;
          bit_n   = 3'd0;
          tx_n    = 1'b0;
          busy_n  = 1'b1;
          state_n = START;
        end
      end
      START: begin
        if (wrap) begin
          cnt_n   = '0;
          tx_n    = shreg[0];
          state_n = DATA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (wrap) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
            tx_n  = shreg[bit_n];
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        if (wrap) begin
          cnt_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      tx_q    <= tx_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  // Shadows follow the level actually sent; a query in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r <= 1'b0;
      sh_g <= 1'b0;
      sh_b <= 1'b0;
      f_r  <= 1'b0;
      f_g  <= 1'b0;
      f_b  <= 1'b0;
    end else begin
      if (clr_r) sh_r <= led_r;
      if (clr_g) sh_g <= led_g;
      if (clr_b) sh_b <= led_b;
      f_r <= (f_r & ~clr_r) | query;
      f_g <= (f_g & ~clr_g) | query;
      f_b <= (f_b & ~clr_b) | query;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_led_status_tx.sv
// Bench for led_status_tx: frame-offset reference model checked every cycle,
// plus a serial decoder feeding literal byte/timing expectations.
module tb_led_status_tx;
  localparam int C     = 4;
  localparam int FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       led_r = 1'b0;
  logic       led_g = 1'b0;
  logic       led_b = 1'b0;
  logic [1:0] dbg_state;

  led_status_tx_if bus ();

  led_status_tx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .led_r     (led_r),
    .led_g     (led_g),
    .led_b     (led_b),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each frame is fixed by its first start-bit cycle; outputs follow from the offset into it.
  logic [7:0] up_c [3] = '{8'h52, 8'h47, 8'h42};
  logic [7:0] lo_c [3] = '{8'h72, 8'h67, 8'h62};
  logic [2:0] m_sh = 3'b000;
  logic [2:0] m_f  = 3'b000;
  logic [2:0] m_led, m_req;
  logic       m_active = 1'b0;
  logic       m_found;
  int         m_start = 0;
  int         m_k;
  logic [7:0] m_byte = 8'h00;
  logic       e_tx = 1'b1, e_busy = 1'b0, e_done = 1'b0;

  always @(posedge clk) begin
    cyc   = cyc + 1;
    m_led = {led_b, led_g, led_r};
    if (!rst_n) begin
      m_sh     = 3'b000;
      m_f      = 3'b000;
      m_active = 1'b0;
    end else begin
      if (!m_active || (cyc - 1 - m_start) >= FRAME) begin
        m_req   = (m_led ^ m_sh) | m_f;
        m_found = 1'b0;
        for (int i = 0; i < 3; i++) begin
          if (m_req[i] && !m_found) begin
            m_found  = 1'b1;
            m_byte   = m_led[i] ? up_c[i] : lo_c[i];
            m_sh[i]  = m_led[i];
            m_f[i]   = 1'b0;
            m_active = 1'b1;
            m_start  = cyc;
          end
        end
      end
      if (bus.rx_done && bus.rx_byte == 8'h3F) m_f = 3'b111;
    end
    m_k    = cyc - m_start;
    e_tx   = 1'b1;
    e_busy = 1'b0;
    e_done = 1'b0;
    if (m_active && m_k < FRAME) begin
      e_busy = 1'b1;
      if (m_k < C) e_tx = 1'b0;
      else if (m_k < 9 * C) e_tx = m_byte[(m_k - C) / C];
    end else if (m_active && m_k == FRAME) begin
      e_done = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("tx_in_reset", 32'(bus.tx), 32'd1);
      chk("busy_in_reset", 32'(bus.tx_busy), 32'd0);
      chk("done_in_reset", 32'(bus.tx_done), 32'd0);
    end else begin
      chk("tx", 32'(bus.tx), 32'(e_tx));
      chk("tx_busy", 32'(bus.tx_busy), 32'(e_busy));
      chk("tx_done", 32'(bus.tx_done), 32'(e_done));
    end
  end

  // ---------------- serial decoder / scoreboard ----------------
  logic [7:0] rx_q [$];
  int         start_q [$];
  int         done_q [$];
  logic [7:0] exp_q [$];
  logic       dec_active = 1'b0;
  int         dec_start = 0;
  int         dec_k;
  logic [7:0] dec_byte = 8'h00;

  always @(negedge clk) begin
    if (!rst_n) begin
      dec_active = 1'b0;
    end else if (!dec_active) begin
      if (bus.tx == 1'b0) begin
        dec_active = 1'b1;
        dec_start  = cyc;
      end
    end else begin
      dec_k = cyc - dec_start;
      if (dec_k >= C + C / 2 && dec_k < 9 * C && ((dec_k - C / 2) % C) == 0)
        dec_byte[(dec_k - C / 2) / C - 1] = bus.tx;
      if (dec_k == 9 * C + C / 2) begin
        chk("stop_bit", 32'(bus.tx), 32'd1);
        rx_q.push_back(dec_byte);
        start_q.push_back(dec_start);
        dec_active = 1'b0;
      end
    end
    if (rst_n && bus.tx_done) done_q.push_back(cyc);
  end

  task automatic clear_q();
    rx_q.delete();
    start_q.delete();
    done_q.delete();
    exp_q.delete();
  endtask

  task automatic check_frames(input string name);
    chk({name, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
      chk({name, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    bus.rx_byte = b;
    bus.rx_done = 1'b1;
    wait_cycles(1);
    bus.rx_done = 1'b0;
    bus.rx_byte = 8'h00;
  endtask

  int n;

  initial begin
    bus.rx_byte = 8'h00;
    bus.rx_done = 1'b0;
    wait_cycles(2);
    chk("reset_tx", 32'(bus.tx), 32'd1);
    chk("reset_busy", 32'(bus.tx_busy), 32'd0);
    chk("reset_done", 32'(bus.tx_done), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // Quiet line with all LEDs off
    wait_cycles(200);
    chk("quiet_frames", 32'(rx_q.size()), 32'd0);
    chk("quiet_done", 32'(done_q.size()), 32'd0);

    // Single red rise
    clear_q();
    n = cyc;
    led_r = 1'b1;
    wait_cycles(50);
    exp_q.push_back(8'h52);
    check_frames("red_rise");
    if (start_q.size() > 0) chk("red_start_cycle", 32'(start_q[0]), 32'(n + 1));
    chk("red_done_count", 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) chk("red_done_cycle", 32'(done_q[0]), 32'(n + 41));

    // All three rise together: R, G, B back to back with 41-cycle spacing
    led_r = 1'b0;
    wait_cycles(50);
    clear_q();
    n = cyc;
    led_r = 1'b1;
    led_g = 1'b1;
    led_b = 1'b1;
    wait_cycles(3 * 41 + 10);
    exp_q = '{8'h52, 8'h47, 8'h42};
    check_frames("rgb_rise");
    if (start_q.size() == 3) begin
      chk("rgb_start0", 32'(start_q[0]), 32'(n + 1));
      chk("rgb_start1", 32'(start_q[1]), 32'(n + 42));
      chk("rgb_start2", 32'(start_q[2]), 32'(n + 83));
    end

    // Query with R=1 G=0 B=1 settled, then a non-query byte
    led_g = 1'b0;
    wait_cycles(50);
    clear_q();
    send_rx(8'h3F);
    wait_cycles(3 * 41 + 10);
    exp_q = '{8'h52, 8'h67, 8'h42};
    check_frames("query");
    clear_q();
    send_rx(8'h41);
    wait_cycles(60);
    check_frames("non_query");

    // Red glitch during a red frame is absorbed; green change follows
    led_r = 1'b0;
    wait_cycles(50);
    clear_q();
    led_r = 1'b1;
    wait_cycles(6);
    led_r = 1'b0;
    wait_cycles(2);
    led_r = 1'b1;
    wait_cycles(2);
    led_g = 1'b1;
    wait_cycles(2 * 41 + 20);
    exp_q = '{8'h52, 8'h47};
    check_frames("glitch");

    // Reset in the middle of a data bit
    led_r = 1'b0;
    led_g = 1'b0;
    wait_cycles(2 * 41 + 10);
    clear_q();
    led_r = 1'b1;
    wait_cycles(3 * C + 1);
    chk("pre_reset_busy", 32'(bus.tx_busy), 32'd1);
    rst_n = 1'b0;
    led_r = 1'b0;
    #1;
    chk("async_reset_tx", 32'(bus.tx), 32'd1);
    chk("async_reset_busy", 32'(bus.tx_busy), 32'd0);
    wait_cycles(3);
    rst_n = 1'b1;
    n = cyc;
    wait_cycles(60);
    exp_q = '{8'h42};
    check_frames("after_reset");
    if (start_q.size() > 0) chk("after_reset_start", 32'(start_q[0]), 32'(n + 1));
    chk("after_reset_done", 32'(done_q.size()), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
